// File: rtl/chunked_seq_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM encoding,
// default geometry for ALU wrappers, and the full-adder bit cell.
package chunked_seq_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/chunked_seq_adder_ripple.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top
// bit so the caller can form signed overflow on the final chunk.
module ripple_chunk_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] c;

  always_comb begin
    s_o  = '0;
    c    = '0;
    c[0] = ci_i;
    for (int i = 0; i < CHUNK; i++) begin
      {c[i+1], s_o[i]} = full_add(a_i[i], b_i[i], c[i]);
    end
  end

  assign co_o    = c[CHUNK];
  assign c_msb_o = c[CHUNK-1];

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle two's-complement add/sub, CHUNK bits per clock with a registered
// inter-chunk carry and a start/done handshake.
//   state | meaning
//   IDLE  | waiting for start; ready high; results held
//   RUN   | one chunk per edge; results update on the last chunk
module chunked_seq_adder
  import chunked_seq_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] data_a_i,
  input  logic [WIDTH-1:0] data_b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_out_o,
  output logic             overflow_o
);

  localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int N          = (WIDTH / SAFE_CHUNK < 1) ? 1 : WIDTH / SAFE_CHUNK;
  localparam int CW         = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((CHUNK < 1) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_cfg
    $error("chunked_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  a_q, b_q, acc_q, acc_d;
  logic              carry_q;
  logic [WIDTH-1:0]  result_q;
  logic              cout_q, ovf_q, done_q;

  logic [CHUNK-1:0]  chunk_sum;
  logic              chunk_co, chunk_cmsb;

  ripple_chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (a_q[CHUNK-1:0]),
    .b_i     (b_q[CHUNK-1:0]),
    .ci_i    (carry_q),
    .s_o     (chunk_sum),
    .co_o    (chunk_co),
    .c_msb_o (chunk_cmsb)
  );

  // Each chunk sum enters at the top; after N shifts chunk 0 sits at the bottom.
  always_comb begin
    acc_d                  = acc_q >> CHUNK;
    acc_d[WIDTH-1 -: CHUNK] = chunk_sum;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= data_a_i;
            b_q     <= data_b_i ^ {WIDTH{sub_i}};
            carry_q <= sub_i;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          acc_q   <= acc_d;
          carry_q <= chunk_co;
          if (cnt_q == LAST) begin
            result_q <= acc_d;
            cout_q   <= chunk_co;
            ovf_q    <= chunk_cmsb ^ chunk_co;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign carry_out_o = cout_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: three instances (CHUNK 8, 32, 4) checked each
// cycle against an arithmetic a+/-b model, plus directed literal cases.
module tb_chunked_seq_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start [3];
  logic        sub   [3];
  logic [31:0] da    [3];
  logic [31:0] db    [3];
  logic        ready [3];
  logic        done  [3];
  logic [31:0] res   [3];
  logic        cout  [3];
  logic        ovf   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 8 : ((g == 1) ? 32 : 4);
    chunked_seq_adder #(.WIDTH(32), .CHUNK(CH)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start[g]),
      .sub_i       (sub[g]),
      .data_a_i    (da[g]),
      .data_b_i    (db[g]),
      .ready_o     (ready[g]),
      .done_o      (done[g]),
      .result_o    (res[g]),
      .carry_out_o (cout[g]),
      .overflow_o  (ovf[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h (t=%0t)", name, k, got, exp, $time);
    end
  endtask

  function automatic int n_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
  endfunction

  // ---------------- behavioural model ----------------
  int          rem      [3];
  int          accepted [3];
  logic        m_done   [3];
  logic [31:0] m_res    [3];
  logic        m_c      [3];
  logic        m_v      [3];
  logic [31:0] p_res    [3];
  logic        p_c      [3];
  logic        p_v      [3];
  bit          armed = 1'b0;

  task automatic compute(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, t;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    t  = s ? (sa - sb) : (sa + sb);
    p_res[k] = t[31:0];
    p_v[k]   = (t > 64'sd2147483647) || (t < -64'sd2147483648);
    p_c[k]   = s ? (ua >= ub) : ((ua + ub) >= 64'h1_0000_0000);
  endtask

  always @(posedge clk) begin
    armed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        rem[k] = 0; m_done[k] = 1'b0;
        m_res[k] = '0; m_c[k] = 1'b0; m_v[k] = 1'b0;
      end else begin
        m_done[k] = 1'b0;
        if (rem[k] == 0) begin
          if (start[k]) begin
            compute(k, da[k], db[k], sub[k]);
            rem[k] = n_of(k);
            accepted[k]++;
          end
        end else begin
          rem[k]--;
          if (rem[k] == 0) begin
            m_res[k] = p_res[k]; m_c[k] = p_c[k]; m_v[k] = p_v[k];
            m_done[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        check("ready",    k, 32'(ready[k]), 32'(rem[k] == 0));
        check("done",     k, 32'(done[k]),  32'(m_done[k]));
        check("result",   k, res[k],        m_res[k]);
        check("carry",    k, 32'(cout[k]),  32'(m_c[k]));
        check("overflow", k, 32'(ovf[k]),   32'(m_v[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic s);
    start[k] = 1'b1; sub[k] = s; da[k] = a; db[k] = b;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!done[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done[k]) check("done_timeout", k, 32'(done[k]), 32'd1);
  endtask

  task automatic lit_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic ec, input logic ev, input string name);
    int lat;
    start_op(k, a, b, s);
    wait_done(k, lat);
    check({name, "_lat"}, k, 32'(lat), 32'(n_of(k)));
    check({name, "_res"}, k, res[k], er);
    check({name, "_c"},   k, 32'(cout[k]), 32'(ec));
    check({name, "_v"},   k, 32'(ovf[k]),  32'(ev));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int cyc;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; sub[k] = 1'b0; da[k] = '0; db[k] = '0;
      rem[k] = 0; accepted[k] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 0, 32'(ready[0]), 32'd1);
    check("rst_done",  0, 32'(done[0]),  32'd0);
    check("rst_res",   0, res[0],        32'd0);
    check("rst_c",     0, 32'(cout[0]),  32'd0);
    check("rst_v",     0, 32'(ovf[0]),   32'd0);

    lit_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    lit_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_ripple");
    lit_op(0, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_borrow");
    lit_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    lit_op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "n1_add");
    lit_op(2, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "n8_sub");

    // start pulsed mid-RUN must be ignored
    start_op(0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    start[0] = 1'b1; sub[0] = 1'b1; da[0] = 32'hDEAD_BEEF; db[0] = 32'h0BAD_F00D;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, lat);
    check("ign_res", 0, res[0], 32'h3333_3333);
    @(negedge clk);
    check("ign_ready", 0, 32'(ready[0]), 32'd1);

    // back-to-back: start in the done cycle
    start_op(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    wait_done(0, lat);
    start_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1);
    wait_done(0, lat);
    check("b2b_lat", 0, 32'(lat), 32'd4);
    check("b2b_res", 0, res[0], 32'hFFFF_FFFE);
    check("b2b_c",   0, 32'(cout[0]), 32'd0);
    @(negedge clk);
    check("done_width", 0, 32'(done[0]), 32'd0);

    // reset during chunk 2
    start_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_res",   0, res[0],        32'd0);
    check("abort_c",     0, 32'(cout[0]),  32'd0);
    check("abort_v",     0, 32'(ovf[0]),   32'd0);
    check("abort_ready", 0, 32'(ready[0]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("abort_nodone", 0, 32'(done[0]), 32'd0);
      @(negedge clk);
    end

    // random phase on all three instances
    for (int k = 0; k < 3; k++) accepted[k] = 0;
    cyc = 0;
    while ((accepted[0] < 1000 || accepted[1] < 1000 || accepted[2] < 1000) && cyc < 40000) begin
      for (int k = 0; k < 3; k++) begin
        start[k] = ($urandom_range(0, 3) != 0);
        sub[k]   = 1'($urandom_range(0, 1));
        da[k]    = pick();
        db[k]    = pick();
      end
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      check("rand_count", k, 32'(accepted[k] >= 1000), 32'd1);
    end
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
